// File: rtl/riscv_lsu.sv
// Load/store unit: one memory access per core request; optional misalign trap via LSU_MISALIGN_EN.
// Latency >= 3 cycles (request, BUSY until mem_ready_i or watchdog, DONE); core_stall_o holds the core.
// Backpressure: the memory stalls via mem_ready_i; the core is held off with core_stall_o.
module riscv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter logic [31:0] RD_RESET       = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        bus_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
`ifdef LSU_MISALIGN_EN
  output logic        misalign_o,
`endif
  input  logic        mem_ready_i
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wd_q, mem_wd_d;
  logic [2:0]      size_q, size_d;
  logic [1:0]      off_q, off_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            bus_err_q, bus_err_d;
  logic [31:0]     rd_q, rd_d;
`ifdef LSU_MISALIGN_EN
  logic            misalign_q, misalign_d;
`endif

  logic            in_byte, in_half, mis_in;
  logic            q_byte, q_half, q_sext;
  logic [3:0]      be_in;
  logic [31:0]     wd_in, ld_val;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic            stall;

  // Size codes 3, 6 and 7 fall through to word handling.
  always_comb begin
    in_byte = (core_size_i[1:0] == 2'b00);
    in_half = (core_size_i[1:0] == 2'b01);
    be_in   = 4'b1111;
    wd_in   = core_wd_i;
    if (in_byte) begin
      be_in = 4'b0001 << core_addr_i[1:0];
      wd_in = {4{core_wd_i[7:0]}};
    end else if (in_half) begin
      be_in = core_addr_i[1] ? 4'b1100 : 4'b0011;
      wd_in = {2{core_wd_i[15:0]}};
    end
`ifdef LSU_MISALIGN_EN
    mis_in = (in_half && core_addr_i[0]) ||
             (!in_byte && !in_half && (core_addr_i[1:0] != 2'b00));
`else
    mis_in = 1'b0;
`endif
    q_byte = (size_q[1:0] == 2'b00);
    q_half = (size_q[1:0] == 2'b01);
    q_sext = !size_q[2];
    lane_b = mem_rd_i[{off_q, 3'b000} +: 8];
    lane_h = mem_rd_i[{off_q[1], 4'b0000} +: 16];
    ld_val = mem_rd_i;
    if (q_byte) begin
      ld_val = {{24{q_sext & lane_b[7]}}, lane_b};
    end else if (q_half) begin
      ld_val = {{16{q_sext & lane_h[15]}}, lane_h};
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_be_d   = mem_be_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    size_d     = size_q;
    off_d      = off_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    bus_err_d  = 1'b0;
`ifdef LSU_MISALIGN_EN
    misalign_d = 1'b0;
`endif
    stall      = 1'b0;
    case (state_q)
      IDLE: begin
        stall = core_req_i;
        if (core_req_i) begin
          if (mis_in) begin
            state_d = DONE;
`ifdef LSU_MISALIGN_EN
            misalign_d = 1'b1;
`endif
          end else begin
            state_d    = BUSY;
            mem_req_d  = 1'b1;
            mem_we_d   = core_we_i;
            mem_be_d   = be_in;
            mem_addr_d = {core_addr_i[31:2], 2'b00};
            mem_wd_d   = wd_in;
            size_d     = core_size_i;
            off_d      = core_addr_i[1:0];
            cnt_d      = '0;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        // A response arriving on the timeout cycle still completes normally.
        if (mem_ready_i || (TO_EN && (cnt_q == TO_LAST))) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          mem_be_d  = 4'b0000;
          if (mem_ready_i) begin
            if (!mem_we_q) rd_d = ld_val;
          end else begin
            bus_err_d = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_be_q   <= 4'b0000;
      mem_addr_q <= 32'h0;
      mem_wd_q   <= 32'h0;
      size_q     <= 3'd0;
      off_q      <= 2'd0;
      cnt_q      <= '0;
      bus_err_q  <= 1'b0;
      rd_q       <= RD_RESET;
`ifdef LSU_MISALIGN_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_be_q   <= mem_be_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      size_q     <= size_d;
      off_q      <= off_d;
      cnt_q      <= cnt_d;
      bus_err_q  <= bus_err_d;
      rd_q       <= rd_d;
`ifdef LSU_MISALIGN_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign core_rd_o    = rd_q;
  assign core_stall_o = stall;
  assign bus_err_o    = bus_err_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_be_o     = mem_be_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wd_o     = mem_wd_q;
`ifdef LSU_MISALIGN_EN
  assign misalign_o   = misalign_q;
`endif

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: transaction-level model drives per-cycle expectations, randomized accesses.
module tb_riscv_lsu;
  localparam int unsigned TO   = 6;
  localparam logic [31:0] RDR  = 32'hC0DE0001;
  localparam logic [31:0] RDR4 = 32'h5A5A0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        core_req, core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr, core_wd, core_rd;
  logic        core_stall, bus_err, mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_ready;
`ifdef LSU_MISALIGN_EN
  logic        misalign, mis4;
`endif

  logic        req4, we4, stall4, err4, mreq4, mwe4, rdy4;
  logic [2:0]  size4;
  logic [31:0] addr4, wd4, rd4, maddr4, mwd4, mrd4;
  logic [3:0]  mbe4;

  riscv_lsu #(.TIMEOUT_CYCLES(TO), .RD_RESET(RDR)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_size_i(core_size),
    .core_addr_i(core_addr), .core_wd_i(core_wd), .core_rd_o(core_rd),
    .core_stall_o(core_stall), .bus_err_o(bus_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wd_o(mem_wd), .mem_rd_i(mem_rd),
`ifdef LSU_MISALIGN_EN
    .misalign_o(misalign),
`endif
    .mem_ready_i(mem_ready)
  );

  riscv_lsu #(.TIMEOUT_CYCLES(4), .RD_RESET(RDR4)) u_to4 (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(req4), .core_we_i(we4), .core_size_i(size4),
    .core_addr_i(addr4), .core_wd_i(wd4), .core_rd_o(rd4),
    .core_stall_o(stall4), .bus_err_o(err4),
    .mem_req_o(mreq4), .mem_we_o(mwe4), .mem_be_o(mbe4),
    .mem_addr_o(maddr4), .mem_wd_o(mwd4), .mem_rd_i(mrd4),
`ifdef LSU_MISALIGN_EN
    .misalign_o(mis4),
`endif
    .mem_ready_i(rdy4)
  );

  int n_vec = 0;
  int n_err = 0;

  bit          chk_en = 1'b0;
  logic        exp_stall, exp_req, exp_err, exp_we, exp_mis, exp_chk_mem;
  logic [3:0]  exp_be;
  logic [31:0] exp_rd, exp_addr, exp_wd;

  logic [3:0]  cap_be;
  logic [31:0] cap_addr, cap_wd;
  int          run = 0;
  int          last_run = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, want %08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Access kind from the size code: 0 = byte, 1 = half, 2 = word.
  function automatic int kind(input logic [2:0] sz);
    case (sz)
      3'd0, 3'd4: return 0;
      3'd1, 3'd5: return 1;
      default:    return 2;
    endcase
  endfunction

  function automatic logic [3:0] be_of(input logic [2:0] sz, input logic [31:0] a);
    int k = kind(sz);
    if (k == 0) return 4'(1 << a[1:0]);
    if (k == 1) return 4'(3 << (2 * a[1]));
    return 4'hF;
  endfunction

  function automatic logic [31:0] wd_of(input logic [2:0] sz, input logic [31:0] wd);
    int k = kind(sz);
    if (k == 0) return 32'(wd[7:0]) * 32'h01010101;
    if (k == 1) return 32'(wd[15:0]) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] ld_of(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] r);
    int k = kind(sz);
    logic [31:0] v;
    if (k == 0) begin
      v = (r >> (8 * a[1:0])) & 32'hFF;
      if (sz < 3'd4 && v[7]) v = v | 32'hFFFFFF00;
    end else if (k == 1) begin
      v = (r >> (16 * a[1])) & 32'hFFFF;
      if (sz < 3'd4 && v[15]) v = v | 32'hFFFF0000;
    end else begin
      v = r;
    end
    return v;
  endfunction

  function automatic bit mis_of(input logic [2:0] sz, input logic [31:0] a);
    int k = kind(sz);
    return ((k == 1) && a[0]) || ((k == 2) && (a[1:0] != 2'b00));
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall",   32'(core_stall), 32'(exp_stall));
      chk("mem_req", 32'(mem_req),    32'(exp_req));
      chk("mem_be",  32'(mem_be),     32'(exp_be));
      chk("bus_err", 32'(bus_err),    32'(exp_err));
      chk("core_rd", core_rd,         exp_rd);
      if (exp_chk_mem) begin
        chk("mem_we",   32'(mem_we), 32'(exp_we));
        chk("mem_addr", mem_addr,    exp_addr);
        chk("mem_wd",   mem_wd,      exp_wd);
      end
`ifdef LSU_MISALIGN_EN
      chk("misalign", 32'(misalign), 32'(exp_mis));
`endif
    end
    if (mem_req) begin
      cap_be   = mem_be;
      cap_addr = mem_addr;
      cap_wd   = mem_wd;
    end
    if (core_stall) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      core_req  = 1'b0;
      mem_ready = 1'($urandom);
      mem_rd    = $urandom;
      exp_stall = 1'b0; exp_req = 1'b0; exp_be = 4'h0; exp_err = 1'b0; exp_mis = 1'b0;
    end
  endtask

  // Returns with the DONE cycle's inputs driven and expectations set.
  task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdat, input int wait_n);
    bit to, mis;
    int busy_n;
    mis = 1'b0;
`ifdef LSU_MISALIGN_EN
    mis = mis_of(sz, a);
`endif
    to     = (TO > 0) && (wait_n + 1 > int'(TO));
    busy_n = mis ? 0 : (to ? int'(TO) : wait_n + 1);
    step();
    core_req = 1'b1; core_we = we; core_size = sz; core_addr = a; core_wd = wd;
    mem_ready = 1'($urandom); mem_rd = $urandom;
    exp_stall = 1'b1; exp_req = 1'b0; exp_be = 4'h0; exp_err = 1'b0; exp_mis = 1'b0;
    exp_chk_mem = 1'b0;
    for (int k = 1; k <= busy_n; k++) begin
      step();
      mem_ready = (k == wait_n + 1);
      mem_rd    = mem_ready ? rdat : $urandom;
      exp_req = 1'b1; exp_stall = 1'b1; exp_be = be_of(sz, a);
      exp_addr = a & 32'hFFFFFFFC; exp_wd = wd_of(sz, wd); exp_we = we; exp_chk_mem = 1'b1;
    end
    step();
    core_req = 1'($urandom); core_we = 1'($urandom); core_size = 3'($urandom);
    core_addr = $urandom; core_wd = $urandom;
    mem_ready = 1'($urandom); mem_rd = $urandom;
    exp_req = 1'b0; exp_be = 4'h0; exp_stall = 1'b0; exp_chk_mem = 1'b0;
    exp_err = to && !mis; exp_mis = mis;
    if (!we && !to && !mis) exp_rd = ld_of(sz, a, rdat);
  endtask

  task automatic reset_values();
    exp_stall = 1'b0; exp_req = 1'b0; exp_be = 4'h0; exp_err = 1'b0; exp_mis = 1'b0;
    exp_rd = RDR; exp_addr = 32'h0; exp_wd = 32'h0; exp_we = 1'b0; exp_chk_mem = 1'b1;
  endtask

  task automatic reset_mid();
    step();
    core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h00005554; core_wd = $urandom;
    mem_ready = 1'b0;
    exp_stall = 1'b1; exp_req = 1'b0; exp_be = 4'h0; exp_err = 1'b0; exp_mis = 1'b0; exp_chk_mem = 1'b0;
    repeat (2) begin
      step();
      exp_req = 1'b1; exp_stall = 1'b1; exp_be = 4'hF; exp_addr = 32'h00005554;
      exp_we = 1'b0; exp_wd = core_wd; exp_chk_mem = 1'b1;
    end
    rst_n = 1'b0;
    step();
    core_req = 1'b0;
    reset_values();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic timeout4();
    step();
    req4 = 1'b1; we4 = 1'b0; size4 = 3'd2; addr4 = 32'h40; wd4 = 32'h0; mrd4 = 32'hBAD0BAD0;
    settle();
    chk("to4_stall_req", 32'(stall4), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      step();
      settle();
      chk("to4_busy_req", 32'(mreq4), 32'd1);
      chk("to4_busy_err", 32'(err4), 32'd0);
    end
    step();
    req4 = 1'b0;
    settle();
    chk("to4_done_err",   32'(err4),   32'd1);
    chk("to4_done_stall", 32'(stall4), 32'd0);
    chk("to4_done_req",   32'(mreq4),  32'd0);
    chk("to4_rd_kept",    rd4,         RDR4);
    step();
    req4 = 1'b1;
    settle();
    chk("to4_idle_err",   32'(err4),   32'd0);
    chk("to4_idle_stall", 32'(stall4), 32'd1);
    chk("to4_idle_req",   32'(mreq4),  32'd0);
    step();
    req4 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_size = 3'd0; core_addr = 32'h0; core_wd = 32'h0;
    mem_rd = 32'h0; mem_ready = 1'b0;
    req4 = 1'b0; we4 = 1'b0; size4 = 3'd0; addr4 = 32'h0; wd4 = 32'h0; mrd4 = 32'h0; rdy4 = 1'b0;
    reset_values();
    step();
    step();
    chk_en = 1'b1;
    step();
    rst_n = 1'b1;
    idle(2);
    exp_chk_mem = 1'b1;

    timeout4();

    access(1'b1, 3'd0, 32'h00001003, 32'h000000A5, $urandom, 0);
    settle();
    chk("sb_be",   32'(cap_be), 32'h8);
    chk("sb_wd",   cap_wd,      32'hA5A5A5A5);
    chk("sb_addr", cap_addr,    32'h00001000);
    chk("sb_run",  last_run,    2);
    chk("sb_rd",   core_rd,     RDR);

    access(1'b0, 3'd0, 32'h00002001, 32'h0, 32'h123480FF, 0);
    settle();
    chk("lb_rd", core_rd, 32'hFFFFFF80);
    access(1'b0, 3'd4, 32'h00002001, 32'h0, 32'h123480FF, 0);
    settle();
    chk("lbu_rd", core_rd, 32'h00000080);
    access(1'b0, 3'd5, 32'h00002002, 32'h0, 32'h80010000, 5);
    settle();
    chk("lhu_rd",   core_rd,  32'h00008001);
    chk("lhu_run",  last_run, 7);
    chk("lhu_addr", cap_addr, 32'h00002000);

    reset_mid();
    access(1'b0, 3'd2, 32'h00004000, 32'h0, 32'hDEADBEEF, 1);
    settle();
    chk("lw_after_rst", core_rd, 32'hDEADBEEF);

`ifdef LSU_MISALIGN_EN
    access(1'b0, 3'd2, 32'h00003002, 32'h0, 32'h11111111, 0);
    settle();
    chk("mis_run", last_run, 1);
    chk("mis_rd",  core_rd,  32'hDEADBEEF);
`endif

    for (int i = 0; i < 200; i++) begin
      access(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 8));
      idle($urandom_range(0, 2));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
